// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job controller: controller states and default operand width.
package gcd_pkg;

    localparam int unsigned GcdWidth = 16;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StRelease,
        StResp
    } gcd_state_e;

endpackage

// File: rtl/gcd_sat_counter.sv
// Saturating up-counter; clr wins over inc, and the count sticks at all-ones.
module gcd_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/gcd_job_ctrl.sv
// Job wrapper around an external GCD core: accepts operand pairs, bypasses zero operands,
// runs the core, waits for it to drop done, and holds the result until consumed.
module gcd_job_ctrl
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GcdWidth,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             gcd_go,
    output logic [WIDTH-1:0] gcd_x,
    output logic [WIDTH-1:0] gcd_y,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic [CNT_W-1:0] out_cycles
);

    gcd_state_e       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d;
    logic             err_q, err_d;
    logic             cnt_clr;
    logic             in_zero;

    assign in_zero = (in_x == '0) || (in_y == '0);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        res_d   = res_q;
        err_d   = err_q;
        cnt_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d     = in_x;
                    y_d     = in_y;
                    cnt_clr = 1'b1;
                    // Zero operands never reach the core; the answer is known already.
                    if (in_zero) begin
                        res_d   = in_x | in_y;
                        err_d   = (in_x == '0) && (in_y == '0);
                        state_d = StResp;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (gcd_done) begin
                    res_d   = gcd_result;
                    err_d   = 1'b0;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (!gcd_done) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    gcd_sat_counter #(
        .CNT_W(CNT_W)
    ) u_busy_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (state_q == StIssue),
        .count(out_cycles)
    );

    assign in_ready  = (state_q == StIdle);
    assign gcd_go    = (state_q == StIssue);
    assign out_valid = (state_q == StResp);
    assign gcd_x     = x_q;
    assign gcd_y     = y_q;
    assign out_gcd   = res_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_gcd_job_ctrl.sv
// Directed bench for gcd_job_ctrl: two instances (16-bit and 3-bit cycle counters), each
// driving a subtract/swap GCD core model that loads on go and holds done until go drops.
module tb_gcd_job_ctrl;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       in_valid, in_ready, gcd_go, gcd_done, out_valid, out_ready, out_err;
    logic [1:0][15:0] in_x, in_y, gcd_x, gcd_y, gcd_result, out_gcd;
    logic [15:0]      cyc0;
    logic [2:0]       cyc1;
    logic [33:0]      core0, core1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gcd_job_ctrl #(.WIDTH(16), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_x(in_x[0]), .in_y(in_y[0]), .gcd_go(gcd_go[0]), .gcd_x(gcd_x[0]),
        .gcd_y(gcd_y[0]), .gcd_done(gcd_done[0]), .gcd_result(gcd_result[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_gcd(out_gcd[0]),
        .out_err(out_err[0]), .out_cycles(cyc0)
    );

    gcd_job_ctrl #(.WIDTH(16), .CNT_W(3)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_x(in_x[1]), .in_y(in_y[1]), .gcd_go(gcd_go[1]), .gcd_x(gcd_x[1]),
        .gcd_y(gcd_y[1]), .gcd_done(gcd_done[1]), .gcd_result(gcd_result[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_gcd(out_gcd[1]),
        .out_err(out_err[1]), .out_cycles(cyc1)
    );

    // Core state packed as {st[1:0], x, y}; st 0=idle, 1=busy, 2=done.
    function automatic logic [33:0] core_step(input logic [33:0] s, input logic go,
                                              input logic [15:0] gx, input logic [15:0] gy);
        logic [1:0]  st;
        logic [15:0] x, y;
        st = s[33:32];
        x  = s[31:16];
        y  = s[15:0];
        case (st)
            2'd0: if (go) return {2'd1, gx, gy};
            2'd1: begin
                if (y == 16'd0) return {2'd2, x, y};
                else if (x < y) return {2'd1, y, x};
                else return {2'd1, x - y, y};
            end
            2'd2: if (!go) return {2'd0, x, y};
            default: return 34'd0;
        endcase
        return s;
    endfunction

    always @(posedge clk) core0 <= rst ? 34'd0 : core_step(core0, gcd_go[0], gcd_x[0], gcd_y[0]);
    always @(posedge clk) core1 <= rst ? 34'd0 : core_step(core1, gcd_go[1], gcd_x[1], gcd_y[1]);

    assign gcd_done[0]   = (core0[33:32] == 2'd2);
    assign gcd_done[1]   = (core1[33:32] == 2'd2);
    assign gcd_result[0] = core0[31:16];
    assign gcd_result[1] = core1[31:16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Offers (a,b) on instance i at a negedge; returns at the first negedge with out_valid.
    // lat = edges from the accept edge (counted as 1) to the edge that first samples out_valid.
    task automatic run_job(input int i, input logic [15:0] a, input logic [15:0] b,
                           output int lat, output int go_cycles);
        int edges;
        in_valid[i] = 1'b1;
        in_x[i]     = a;
        in_y[i]     = b;
        check_eq("in_ready_before_accept", 32'(in_ready[i]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[i] = 1'b0;
        edges       = 1;
        go_cycles   = 0;
        while (!out_valid[i] && edges < 2000) begin
            go_cycles += int'(gcd_go[i]);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        go_cycles += int'(gcd_go[i]);
        check_eq("out_valid_reached", 32'(out_valid[i]), 32'd1);
        lat = edges + 1;
    endtask

    initial begin
        int lat, go_n;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        in_x      = '0;
        in_y      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        check_eq("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check_eq("rst_gcd_go", 32'(gcd_go[0]), 32'd0);
        check_eq("rst_out_gcd", 32'(out_gcd[0]), 32'd0);
        check_eq("rst_out_err", 32'(out_err[0]), 32'd0);
        check_eq("rst_out_cycles", 32'(cyc0), 32'd0);
        check_eq("rst_gcd_x", 32'(gcd_x[0]), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("in_ready_after_rst", 32'(in_ready[0]), 32'd1);

        // (48,18): 8 core steps + load + done detect + done cycle = 11 ISSUE cycles.
        out_ready[0] = 1'b1;
        run_job(0, 16'd48, 16'd18, lat, go_n);
        check_eq("j48_gcd", 32'(out_gcd[0]), 32'd6);
        check_eq("j48_err", 32'(out_err[0]), 32'd0);
        check_eq("j48_cycles", 32'(cyc0), 32'd11);
        check_eq("j48_go_cycles", 32'(go_n), 32'd11);
        @(posedge clk);
        @(negedge clk);
        check_eq("j48_consumed_valid", 32'(out_valid[0]), 32'd0);
        check_eq("j48_consumed_ready", 32'(in_ready[0]), 32'd1);

        run_job(0, 16'd0, 16'd5, lat, go_n);
        check_eq("j05_latency", 32'(lat), 32'd2);
        check_eq("j05_go_cycles", 32'(go_n), 32'd0);
        check_eq("j05_gcd", 32'(out_gcd[0]), 32'd5);
        check_eq("j05_err", 32'(out_err[0]), 32'd0);
        check_eq("j05_cycles", 32'(cyc0), 32'd0);
        @(posedge clk);
        @(negedge clk);

        run_job(0, 16'd0, 16'd0, lat, go_n);
        check_eq("j00_gcd", 32'(out_gcd[0]), 32'd0);
        check_eq("j00_err", 32'(out_err[0]), 32'd1);
        check_eq("j00_cycles", 32'(cyc0), 32'd0);
        check_eq("j00_go_cycles", 32'(go_n), 32'd0);
        @(posedge clk);
        @(negedge clk);

        // (21,14) with the consumer stalled while a bypass pair is offered.
        out_ready[0] = 1'b0;
        run_job(0, 16'd21, 16'd14, lat, go_n);
        check_eq("j2114_cycles", 32'(cyc0), 32'd8);
        in_valid[0] = 1'b1;
        in_x[0]     = 16'd3;
        in_y[0]     = 16'd0;
        for (int k = 0; k < 10; k++) begin
            check_eq("stall_out_valid", 32'(out_valid[0]), 32'd1);
            check_eq("stall_out_gcd", 32'(out_gcd[0]), 32'd7);
            check_eq("stall_in_ready", 32'(in_ready[0]), 32'd0);
            check_eq("stall_gcd_x", 32'(gcd_x[0]), 32'd21);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("stall_released_valid", 32'(out_valid[0]), 32'd0);
        check_eq("stall_released_ready", 32'(in_ready[0]), 32'd1);
        check_eq("stall_released_gcd", 32'(out_gcd[0]), 32'd7);

        // Reset on the 4th ISSUE cycle of (100,75).
        in_valid[0] = 1'b1;
        in_x[0]     = 16'd100;
        in_y[0]     = 16'd75;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        go_n = 0;
        while (go_n < 3 && gcd_go[0]) begin
            go_n++;
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("rst_job_go_4th", 32'(gcd_go[0]), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_gcd_go", 32'(gcd_go[0]), 32'd0);
        check_eq("midrst_out_valid", 32'(out_valid[0]), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready[0]), 32'd1);
        check_eq("midrst_out_cycles", 32'(cyc0), 32'd0);
        check_eq("midrst_out_gcd", 32'(out_gcd[0]), 32'd0);
        check_eq("midrst_gcd_y", 32'(gcd_y[0]), 32'd0);

        run_job(0, 16'd9, 16'd6, lat, go_n);
        check_eq("j96_gcd", 32'(out_gcd[0]), 32'd3);
        check_eq("j96_err", 32'(out_err[0]), 32'd0);
        check_eq("j96_cycles", 32'(cyc0), 32'd8);
        @(posedge clk);
        @(negedge clk);

        // 3-bit counter saturates during the 255-step job.
        out_ready[1] = 1'b1;
        run_job(1, 16'd255, 16'd1, lat, go_n);
        check_eq("sat_gcd", 32'(out_gcd[1]), 32'd1);
        check_eq("sat_cycles", 32'(cyc1), 32'd7);
        check_eq("sat_err", 32'(out_err[1]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("sat_consumed_ready", 32'(in_ready[1]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gcd_job_ctrl.md
GCD_JOB_CTRL -- requirements
Module: gcd_job_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and result width.
REQ-002 SHALL have parameter CNT_W, default 16: cycle-count width.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operand pair offered.
REQ-006 SHALL have port in_ready, output, 1: block accepts the pair this cycle.
REQ-007 SHALL have ports in_x and in_y, input, WIDTH each: unsigned operands.
REQ-008 SHALL have port gcd_go, output, 1: start request to the downstream GCD core.
REQ-009 SHALL have ports gcd_x and gcd_y, output, WIDTH each: operands presented to the core's load path.
REQ-010 SHALL have port gcd_done, input, 1: core completion flag.
REQ-011 SHALL have port gcd_result, input, WIDTH: core result; valid while gcd_done=1.
REQ-012 SHALL have port out_valid, output, 1: result available.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-014 SHALL have ports out_gcd (output, WIDTH), out_err (output, 1) and out_cycles (output, CNT_W): result, both-zero error flag, and core busy cycles.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, RELEASE and RESP.
REQ-016 SHALL drive in_ready=1 only in IDLE; an accept (in_valid & in_ready) SHALL register in_x/in_y into the operand registers.
REQ-017 SHALL, on an accept with both operands nonzero, go to ISSUE with out_cycles cleared.
REQ-018 SHALL, on an accept with either operand zero (bypass), go directly to RESP with out_gcd=in_x|in_y, out_err=(in_x==0 && in_y==0), out_cycles=0, and SHALL NOT assert gcd_go; the core never sees zero operands.
REQ-019 SHALL drive gcd_x/gcd_y from the operand registers, stable from the accept until the next accept.
REQ-020 SHALL assert gcd_go=1 in every ISSUE cycle and only in ISSUE.
REQ-021 SHALL, in ISSUE, increment out_cycles every cycle, saturating at all-ones; the count includes the gcd_done cycle.
REQ-022 SHALL, in ISSUE with gcd_done=1, capture gcd_result into out_gcd, set out_err=0, and go to RELEASE.
REQ-023 SHALL, in RELEASE, hold gcd_go=0 and stay until gcd_done=0, then go to RESP, so no new job can reach a core that is still in its done state.
REQ-024 SHALL assert out_valid=1 in RESP only, with out_gcd/out_err/out_cycles held stable while out_valid=1 && out_ready=0.
REQ-025 SHALL, in RESP with out_ready=1, return to IDLE; a new accept is possible no earlier than the following cycle.
REQ-026 SHALL ignore in_valid outside IDLE and gcd_done outside ISSUE/RELEASE.
REQ-027 SHALL have a bypass latency of 2 edges from accept to out_valid.

Reset
REQ-028 SHALL, on rst=1 at a clk edge, set state IDLE, gcd_go=0, out_valid=0, out_gcd=0, out_err=0, out_cycles=0 and operand registers 0, overriding any in-flight job.
REQ-029 SHALL drive in_ready=1 in the first cycle after rst deasserts.
REQ-030 SHALL share rst with the GCD core so that a reset during ISSUE clears both; no partial result is ever presented.

Structure
REQ-031 SHALL place the state enum (IDLE, ISSUE, RELEASE, RESP) and the WIDTH default in shared package gcd_pkg.
REQ-032 SHALL implement the saturating busy counter as sub-module gcd_sat_counter (inputs clr, inc; output count, CNT_W).

Verification
REQ-033 SHALL cover: (48,18) with the core attached, out_ready=1 -> out_gcd=6, out_err=0, out_cycles=11, gcd_go high for exactly 11 cycles.
REQ-034 SHALL cover: (0,5) -> out_valid 2 edges after accept, out_gcd=5, out_err=0, out_cycles=0, gcd_go never high.
REQ-035 SHALL cover: (0,0) -> out_gcd=0, out_err=1, out_cycles=0.
REQ-036 SHALL cover: (21,14) with out_ready=0 for 10 cycles -> out_valid held, out_gcd=7 stable, in_ready=0 and in_valid ignored throughout.
REQ-037 SHALL cover: rst pulsed on the 4th ISSUE cycle of (100,75) -> next cycle gcd_go=0, out_valid=0, in_ready=1; a following (9,6) returns out_gcd=3.
REQ-038 SHALL cover: CNT_W=3 with (255,1) -> out_cycles saturates at 7 and out_gcd=1.
